// File: rtl/banner_pkg.sv
// Shared constants, state encoding and a width helper for the banner scroller.
package banner_pkg;

    localparam int BANNER_ROWS   = 15;
    localparam int BANNER_WIDTH  = 71;
    localparam int BANNER_ADDR_W = 5;

    // Encoding is fixed so the debug state output stays stable across revisions.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } scroll_state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/banner_wrap_ctr.sv
// Modulo-N counter with clear, load and increment; wrap flags the terminal count N-1.
import banner_pkg::*;

module banner_wrap_ctr #(
    parameter int N = BANNER_WIDTH,
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = (count == W'(N - 1));

    // Priority: clear, then load, then increment with wrap back to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/banner_scroller.sv
// Walks the banner ROM once per frame and serialises a scrolling VIEW_W-wide window.
//
// Handshake: pix_valid is high for the whole EMIT state; a pixel transfers on a
// rising clk edge where pix_valid and pix_ready are both high. Until then
// pix_data, pix_x and pix_y hold and pix_valid never drops.
import banner_pkg::*;

module banner_scroller #(
    parameter int ROWS       = BANNER_ROWS,
    parameter int WIDTH      = BANNER_WIDTH,
    parameter int VIEW_W     = 32,
    parameter int SCROLL_DIV = 4,
    parameter int ADDR_W     = BANNER_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              scroll_en,
    input  logic [WIDTH-1:0]  rom_data,
    input  logic              pix_ready,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              pix_valid,
    output logic              pix_data,
    output logic [6:0]        pix_x,
    output logic [ADDR_W-1:0] pix_y,
    output logic              frame_done,
    output logic              overrun,
    output logic [2:0]        dbg_state
);

    localparam int FC_W = clog2(SCROLL_DIV) + 1;

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_FETCH = ST_FETCH;
    localparam logic [2:0] S_WAIT  = ST_WAIT;
    localparam logic [2:0] S_EMIT  = ST_EMIT;
    localparam logic [2:0] S_DONE  = ST_DONE;

    logic [2:0]        state;
    logic [ADDR_W-1:0] row;
    logic [6:0]        x;
    logic [WIDTH-1:0]  row_reg;
    logic [FC_W-1:0]   frame_cnt;
    logic [6:0]        col;
    logic [6:0]        offset;
    logic              col_wrap;
    logic              off_wrap;
    logic              xfer;
    logic              last_x;
    logic              last_row;
    logic              scroll_step;
    logic              unused_wraps;

    assign xfer        = (state == S_EMIT) && pix_ready;
    assign last_x      = (x == 7'(VIEW_W - 1));
    assign last_row    = (row == ADDR_W'(ROWS - 1));
    assign scroll_step = (state == S_DONE) && scroll_en &&
                         (frame_cnt == FC_W'(SCROLL_DIV - 1));

    assign pix_valid  = (state == S_EMIT);
    assign pix_data   = row_reg[7'(WIDTH - 1) - col];
    assign pix_x      = x;
    assign pix_y      = row;
    assign frame_done = (state == S_DONE);
    assign dbg_state  = state;

    // Terminal flags are not needed here; the counters wrap on their own.
    assign unused_wraps = col_wrap ^ off_wrap;

    // Banner column under the current pixel: starts at offset each row, wraps at WIDTH.
    banner_wrap_ctr #(.N(WIDTH), .W(7)) u_col (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (1'b0),
        .load     (state == S_FETCH),
        .load_val (offset),
        .inc      (xfer),
        .count    (col),
        .wrap     (col_wrap)
    );

    // Scroll offset: advances one column per SCROLL_DIV enabled frames.
    banner_wrap_ctr #(.N(WIDTH), .W(7)) u_offset (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (1'b0),
        .load     (1'b0),
        .load_val (7'd0),
        .inc      (scroll_step),
        .count    (offset),
        .wrap     (off_wrap)
    );

    // Frame sequencer: fetch a row, wait for ROM data, stream VIEW_W pixels, repeat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            row      <= '0;
            x        <= '0;
            row_reg  <= '0;
            rom_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        row      <= '0;
                        rom_addr <= '0;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    x     <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    row_reg <= rom_data;
                    state   <= S_EMIT;
                end
                S_EMIT: begin
                    if (xfer) begin
                        x <= x + 7'd1;
                        if (last_x) begin
                            if (last_row) begin
                                state <= S_DONE;
                            end else begin
                                row      <= row + 1'b1;
                                rom_addr <= row + 1'b1;
                                state    <= S_FETCH;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Frame divider for the scroll step; holds while scroll_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if ((state == S_DONE) && scroll_en) begin
            if (frame_cnt == FC_W'(SCROLL_DIV - 1)) begin
                frame_cnt <= '0;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // One-cycle flag for a frame request arriving while a frame is in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else begin
            overrun <= frame_start && (state != S_IDLE);
        end
    end

endmodule
